axi_ram_slave: RTL

AXI4 memory responder that terminates one master port of `axi_crossbar`, which is the endpoint the crossbar's issued transactions land on. It accepts AW/W/AR bursts, stores them in an internal word-addressed array and returns B and R responses with the ID it received. The read and write paths are independent FSMs over a dual-ported array, so one read burst and one write burst can be in flight at the same time.

---
 rtl/axi_ram_pkg.sv | 14 +
 rtl/axi_ram_addr_gen.sv | 52 +++++
 rtl/axi_ram_slave.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_pkg.sv
// Shared constants and FSM state types for the AXI4 RAM responder.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

endpackage

// File: rtl/axi_ram_addr_gen.sv
// Next-beat address and burst-error decode for one AXI burst.
// AXI_RAM_WRAP_EN enables WRAP bursts; without it WRAP is treated as reserved.
module axi_ram_addr_gen
  import axi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int ADDR_LSB   = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  err
);

  localparam logic [2:0]            MAX_SIZE = 3'(ADDR_LSB);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  logic [2:0]            eff_size;
  logic [ADDR_WIDTH-1:0] inc;
  logic [ADDR_WIDTH-1:0] incr_addr;

  // Sizes wider than the bus step by one full word.
  assign eff_size  = (size > MAX_SIZE) ? MAX_SIZE : size;
  assign inc       = ONE << eff_size;
  assign incr_addr = addr + inc;

`ifdef AXI_RAM_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;
  assign wrap_mask = ((ADDR_WIDTH'(len) + ONE) * inc) - ONE;
`else
  logic unused_len;
  assign unused_len = ^len;
`endif

  always_comb begin
    next_addr = addr;
    err       = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
`ifdef AXI_RAM_WRAP_EN
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`else
      BURST_WRAP:  err = 1'b1;
`endif
      default:     err = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 RAM responder: independent write and read FSMs over a dual-ported word array.
// AXI_RAM_WRAP_EN enables WRAP bursts (otherwise they complete with SLVERR).
module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output w_state_t              dbg_w_state,
  output r_state_t              dbg_r_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid/ready outputs depend only on registered state, never on this cycle's inputs.

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int WORD_AW  = ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH    = 1 << WORD_AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Holds address-channel ready low while reset is asserted and for the first edge after.
  logic live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

  // ---------------- write path ----------------
  w_state_t              w_state, w_state_nx;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len, w_cnt;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_err;
  logic                  aw_fire, w_fire, b_fire, w_last_beat;

  axi_ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .ADDR_LSB(ADDR_LSB)) u_w_gen (
    .addr      (aw_addr),
    .len       (aw_len),
    .size      (aw_size),
    .burst     (aw_burst),
    .next_addr (w_next_addr),
    .err       (w_err)
  );

  assign s_axi_awready = live && (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bid     = aw_id;
  assign s_axi_bresp   = (s_axi_bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign dbg_w_state   = w_state;

  assign aw_fire     = s_axi_awvalid && s_axi_awready;
  assign w_fire      = s_axi_wvalid && s_axi_wready;
  assign b_fire      = s_axi_bvalid && s_axi_bready;
  assign w_last_beat = (w_cnt == aw_len);

  // The beat counter ends the burst; wlast is not consulted.
  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_state_nx = W_DATA;
      W_DATA:  if (w_fire && w_last_beat) w_state_nx = W_RESP;
      W_RESP:  if (b_fire) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      w_cnt    <= '0;
    end else begin
      w_state <= w_state_nx;
      if (aw_fire) begin
        aw_id    <= s_axi_awid;
        aw_addr  <= s_axi_awaddr;
        aw_len   <= s_axi_awlen;
        aw_size  <= s_axi_awsize;
        aw_burst <= s_axi_awburst;
        w_cnt    <= '0;
      end else if (w_fire) begin
        aw_addr <= w_next_addr;
        w_cnt   <= w_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && !w_err) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i])
          mem[aw_addr[ADDR_WIDTH-1:ADDR_LSB]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state, r_state_nx;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len, r_cnt;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] rg_addr, rg_next;
  logic [7:0]            rg_len;
  logic [2:0]            rg_size;
  logic [1:0]            rg_burst;
  logic                  rg_err;
  logic                  ar_fire, r_fire;

  // While idle the generator decodes the incoming AR so the error is known at capture.
  assign rg_addr  = (r_state == R_IDLE) ? s_axi_araddr  : ar_addr;
  assign rg_len   = (r_state == R_IDLE) ? s_axi_arlen   : ar_len;
  assign rg_size  = (r_state == R_IDLE) ? s_axi_arsize  : ar_size;
  assign rg_burst = (r_state == R_IDLE) ? s_axi_arburst : ar_burst;

  axi_ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .ADDR_LSB(ADDR_LSB)) u_r_gen (
    .addr      (rg_addr),
    .len       (rg_len),
    .size      (rg_size),
    .burst     (rg_burst),
    .next_addr (rg_next),
    .err       (rg_err)
  );

  assign s_axi_arready = live && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign s_axi_rid     = ar_id;
  assign s_axi_rlast   = s_axi_rvalid && (r_cnt == ar_len);
  assign s_axi_rresp   = (s_axi_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign dbg_r_state   = r_state;

  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign r_fire  = s_axi_rvalid && s_axi_rready;

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_nx = R_DATA;
      R_DATA:  if (r_fire && s_axi_rlast) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Array reads use the pre-edge contents, so a same-cycle write is not visible here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= R_IDLE;
      ar_id       <= '0;
      ar_addr     <= '0;
      ar_len      <= '0;
      ar_size     <= '0;
      ar_burst    <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      s_axi_rdata <= '0;
    end else begin
      r_state <= r_state_nx;
      if (ar_fire) begin
        ar_id       <= s_axi_arid;
        ar_addr     <= s_axi_araddr;
        ar_len      <= s_axi_arlen;
        ar_size     <= s_axi_arsize;
        ar_burst    <= s_axi_arburst;
        r_cnt       <= '0;
        r_err       <= rg_err;
        s_axi_rdata <= rg_err ? '0 : mem[s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB]];
      end else if (r_fire && !s_axi_rlast) begin
        ar_addr     <= rg_next;
        r_cnt       <= r_cnt + 8'd1;
        s_axi_rdata <= r_err ? '0 : mem[rg_next[ADDR_WIDTH-1:ADDR_LSB]];
      end
    end
  end

endmodule
